// File: rtl/timer_scoreboard_display_pkg.sv
// Shared constants for the scoreboard display: segment patterns, slot map, digit count.
package timer_scoreboard_display_pkg;

  localparam int unsigned NUM_DIGITS = 8;
  localparam int unsigned SLOT_W     = 3;
  localparam int unsigned VAL_W      = 32;

  // Active-low segment patterns, bit order {g,f,e,d,c,b,a}
  localparam logic [6:0] SEG_0     = 7'h40;
  localparam logic [6:0] SEG_1     = 7'h79;
  localparam logic [6:0] SEG_2     = 7'h24;
  localparam logic [6:0] SEG_3     = 7'h30;
  localparam logic [6:0] SEG_4     = 7'h19;
  localparam logic [6:0] SEG_5     = 7'h12;
  localparam logic [6:0] SEG_6     = 7'h02;
  localparam logic [6:0] SEG_7     = 7'h78;
  localparam logic [6:0] SEG_8     = 7'h00;
  localparam logic [6:0] SEG_9     = 7'h10;
  localparam logic [6:0] SEG_DASH  = 7'h3F;
  localparam logic [6:0] SEG_BLANK = 7'h7F;

  localparam logic [NUM_DIGITS-1:0] AN_OFF = 8'hFF;

  // Slot map; slots 3, 4 and 6 are unused and stay blank
  localparam logic [SLOT_W-1:0] SLOT_S1      = SLOT_W'(0);
  localparam logic [SLOT_W-1:0] SLOT_S10     = SLOT_W'(1);
  localparam logic [SLOT_W-1:0] SLOT_M       = SLOT_W'(2);
  localparam logic [SLOT_W-1:0] SLOT_SCORE_R = SLOT_W'(5);
  localparam logic [SLOT_W-1:0] SLOT_SCORE_L = SLOT_W'(7);

endpackage

// File: rtl/timer_scoreboard_display_seg7_decode.sv
// Combinational BCD-to-seven-segment decoder (active-low); anything above 9 shows a dash.
//   value     : 32-bit digit value
//   pattern_c : {g,f,e,d,c,b,a} active-low pattern
module seg7_decode
  import timer_scoreboard_display_pkg::*;
(
  input  logic [VAL_W-1:0] value,
  output logic [6:0]       pattern_c
);

  always_comb begin
    pattern_c = SEG_DASH;
    if (value[VAL_W-1:4] == 28'd0) begin
      case (value[3:0])
        4'd0:    pattern_c = SEG_0;
        4'd1:    pattern_c = SEG_1;
        4'd2:    pattern_c = SEG_2;
        4'd3:    pattern_c = SEG_3;
        4'd4:    pattern_c = SEG_4;
        4'd5:    pattern_c = SEG_5;
        4'd6:    pattern_c = SEG_6;
        4'd7:    pattern_c = SEG_7;
        4'd8:    pattern_c = SEG_8;
        4'd9:    pattern_c = SEG_9;
        default: pattern_c = SEG_DASH;
      endcase
    end
  end

endmodule

// File: rtl/timer_scoreboard_display.sv
// Scans game-clock digits and both player scores onto an 8-digit common-anode display,
// blinks the timer field after expiry and pulses time_up once per expiry.
//   clk, reset        : clock, asynchronous active-low reset
//   m, s10, s1        : game-clock digits (minutes, tens of seconds, seconds)
//   score_l, score_r  : player score digits
//   an                : active-low digit enables, an[0] rightmost
//   seg, dp           : active-low segments {g..a} and decimal point
//   time_up           : one-cycle pulse when the captured clock reaches 0:00
module timer_scoreboard_display
  import timer_scoreboard_display_pkg::*;
#(
  parameter int unsigned REFRESH_DIV = 100000,
  parameter int unsigned BLINK_DIV   = 25000000
)(
  input  logic                  clk,
  input  logic                  reset,
  input  logic [VAL_W-1:0]      m,
  input  logic [VAL_W-1:0]      s10,
  input  logic [VAL_W-1:0]      s1,
  input  logic [3:0]            score_l,
  input  logic [3:0]            score_r,
  output logic [NUM_DIGITS-1:0] an,
  output logic [6:0]            seg,
  output logic                  dp,
  output logic                  time_up
);

  localparam int unsigned REF_W = $clog2(REFRESH_DIV);
  localparam int unsigned BLK_W = $clog2(BLINK_DIV);

  logic [REF_W-1:0]  refresh_cnt;
  logic [SLOT_W-1:0] slot;
  logic [VAL_W-1:0]  m_q, s10_q, s1_q;
  logic [3:0]        score_l_q, score_r_q;
  logic              expired, expired_d;
  logic [BLK_W-1:0]  blink_cnt;
  logic              blink_phase;

  logic              refresh_wrap_c;
  logic              timer_hidden_c;
  logic              slot_lit_c;
  logic [VAL_W-1:0]  digit_val_c;
  logic [6:0]        dec_seg_c;

  assign refresh_wrap_c = (refresh_cnt == REF_W'(REFRESH_DIV - 1));
  // Gate on expired too, so the timer is steady the cycle after expiry clears
  assign timer_hidden_c = expired & blink_phase;

  // Slot timing and input capture; captured values only change at a slot boundary
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      refresh_cnt <= '0;
      slot        <= '0;
      m_q         <= '0;
      s10_q       <= '0;
      s1_q        <= '0;
      score_l_q   <= '0;
      score_r_q   <= '0;
      expired     <= 1'b0;
    end else if (refresh_wrap_c) begin
      refresh_cnt <= '0;
      slot        <= slot + SLOT_W'(1);
      m_q         <= m;
      s10_q       <= s10;
      s1_q        <= s1;
      score_l_q   <= score_l;
      score_r_q   <= score_r;
      expired     <= (m == '0) && (s10 == '0) && (s1 == '0);
    end else begin
      refresh_cnt <= refresh_cnt + REF_W'(1);
    end
  end

  // Blink timebase runs only while expired, so it always restarts in the visible phase
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      blink_cnt   <= '0;
      blink_phase <= 1'b0;
    end else if (!expired) begin
      blink_cnt   <= '0;
      blink_phase <= 1'b0;
    end else if (blink_cnt == BLK_W'(BLINK_DIV - 1)) begin
      blink_cnt   <= '0;
      blink_phase <= ~blink_phase;
    end else begin
      blink_cnt   <= blink_cnt + BLK_W'(1);
    end
  end

  // Rising-edge detect on expired
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      expired_d <= 1'b0;
      time_up   <= 1'b0;
    end else begin
      expired_d <= expired;
      time_up   <= expired & ~expired_d;
    end
  end

  // Select the value shown in the current slot
  always_comb begin
    digit_val_c = '0;
    slot_lit_c  = 1'b0;
    case (slot)
      SLOT_S1: begin
        digit_val_c = s1_q;
        slot_lit_c  = ~timer_hidden_c;
      end
      SLOT_S10: begin
        digit_val_c = s10_q;
        slot_lit_c  = ~timer_hidden_c;
      end
      SLOT_M: begin
        digit_val_c = m_q;
        slot_lit_c  = ~timer_hidden_c;
      end
      SLOT_SCORE_R: begin
        digit_val_c = {28'd0, score_r_q};
        slot_lit_c  = 1'b1;
      end
      SLOT_SCORE_L: begin
        digit_val_c = {28'd0, score_l_q};
        slot_lit_c  = 1'b1;
      end
      default: begin
        digit_val_c = '0;
        slot_lit_c  = 1'b0;
      end
    endcase
  end

  seg7_decode u_decode (
    .value     (digit_val_c),
    .pattern_c (dec_seg_c)
  );

  // Registered display drive
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      an  <= AN_OFF;
      seg <= SEG_BLANK;
      dp  <= 1'b1;
    end else begin
      an  <= slot_lit_c ? ~(NUM_DIGITS'(1) << slot) : AN_OFF;
      seg <= slot_lit_c ? dec_seg_c : SEG_BLANK;
      dp  <= 1'b1;
    end
  end

endmodule

// File: tb/tb_timer_scoreboard_display.sv
// Self-checking bench for timer_scoreboard_display (REFRESH_DIV=4, BLINK_DIV=16).
module tb_timer_scoreboard_display;

  localparam int unsigned RDIV = 4;
  localparam int unsigned BDIV = 16;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic [31:0] m, s10, s1;
  logic [3:0]  score_l, score_r;
  logic [7:0]  an;
  logic [6:0]  seg;
  logic        dp, time_up;

  int total = 0;
  int bad   = 0;

  timer_scoreboard_display #(.REFRESH_DIV(RDIV), .BLINK_DIV(BDIV)) dut (
    .clk(clk), .reset(reset), .m(m), .s10(s10), .s1(s1),
    .score_l(score_l), .score_r(score_r),
    .an(an), .seg(seg), .dp(dp), .time_up(time_up)
  );

  always #5 clk = ~clk;

  // Reference model: mk counts clock edges since reset release; everything derives from it
  int          mk;
  logic [31:0] cm, cs10, cs1;
  logic [3:0]  csl, csr;
  bit          mexp, mexp_prev;
  int          rise;
  logic [7:0]  exp_an;
  logic [6:0]  exp_seg;
  bit          exp_tu;

  function automatic logic [6:0] ref_dec(input logic [31:0] v);
    logic [6:0] r;
    r = 7'h3F;
    if (v <= 32'd9) begin
      case (v[3:0])
        4'd0: r = 7'h40;  4'd1: r = 7'h79;  4'd2: r = 7'h24;  4'd3: r = 7'h30;
        4'd4: r = 7'h19;  4'd5: r = 7'h12;  4'd6: r = 7'h02;  4'd7: r = 7'h78;
        4'd8: r = 7'h00;  4'd9: r = 7'h10;
        default: r = 7'h3F;
      endcase
    end
    return r;
  endfunction

  task automatic model_reset();
    mk = 0; cm = '0; cs10 = '0; cs1 = '0; csl = '0; csr = '0;
    mexp = 0; mexp_prev = 0; rise = 0;
    exp_an = 8'hFF; exp_seg = 7'h7F; exp_tu = 0;
  endtask

  // Called at each active edge while out of reset; outputs after edge mk show the
  // slot and captured values that held after edge mk-1
  task automatic model_step();
    int          sl;
    bit          ph, lit, nexp;
    logic [31:0] v;
    mk++;
    sl = ((mk - 1) / int'(RDIV)) % 8;
    ph = mexp && ((((mk - 1) - rise) / int'(BDIV)) % 2 == 1);
    exp_tu = mexp && !mexp_prev;
    lit = 1; v = '0;
    case (sl)
      0: v = cs1;
      1: v = cs10;
      2: v = cm;
      5: v = {28'd0, csr};
      7: v = {28'd0, csl};
      default: lit = 0;
    endcase
    if (sl <= 2 && ph) lit = 0;
    exp_an  = lit ? ~(8'd1 << sl) : 8'hFF;
    exp_seg = lit ? ref_dec(v) : 7'h7F;
    mexp_prev = mexp;
    if (mk % int'(RDIV) == 0) begin
      cm = m; cs10 = s10; cs1 = s1; csl = score_l; csr = score_r;
      nexp = (m == 0) && (s10 == 0) && (s1 == 0);
      if (nexp && !mexp) rise = mk;
      mexp = nexp;
    end
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h (edge %0d)", name, act, exp, mk);
    end
  endtask

  // One clock: model advances at the edge, DUT sampled on the falling edge
  task automatic tick();
    @(posedge clk);
    if (reset) model_step();
    @(negedge clk);
    chk("model_an",  32'(an),      32'(exp_an));
    chk("model_seg", 32'(seg),     32'(exp_seg));
    chk("model_tu",  32'(time_up), 32'(exp_tu));
    chk("dp",        32'(dp),      32'd1);
  endtask

  task automatic tick_n(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  // Advance until the display is at cycle ph of the 32-cycle scan frame
  task automatic goto_phase(input int ph);
    bit hit;
    hit = 0;
    for (int g = 0; g < 80; g++) begin
      tick();
      if (((mk - 1) % 32) == ph) begin
        hit = 1;
        break;
      end
    end
    if (!hit) begin
      total++; bad++;
      $display("FAIL goto_phase: phase %0d not reached, edge %0d", ph, mk);
    end
  endtask

  task automatic check_frame(input string tag, input logic [6:0] e0, input logic [6:0] e1,
                             input logic [6:0] e2, input logic [6:0] e5, input logic [6:0] e7,
                             input logic [2:0] tlit);
    logic [6:0] es [8];
    logic [7:0] ea;
    bit         lit;
    es = '{e0, e1, e2, 7'h7F, 7'h7F, e5, 7'h7F, e7};
    for (int s = 0; s < 8; s++) begin
      goto_phase(4 * s + 2);
      lit = (s <= 2) ? tlit[s] : (s == 5 || s == 7);
      ea  = lit ? ~(8'd1 << s) : 8'hFF;
      chk($sformatf("%s_an%0d", tag, s), 32'(an), 32'(ea));
      chk($sformatf("%s_seg%0d", tag, s), 32'(seg), lit ? 32'(es[s]) : 32'h7F);
    end
  endtask

  task automatic async_reset(input string tag);
    reset = 1'b0;
    #1;
    model_reset();
    chk({tag, "_an"},  32'(an),      32'hFF);
    chk({tag, "_seg"}, 32'(seg),     32'h7F);
    chk({tag, "_tu"},  32'(time_up), 32'd0);
  endtask

  typedef struct {
    logic [31:0] vm, vs10, vs1;
    logic [3:0]  vsl, vsr;
    logic [6:0]  e0, e1, e2, e5, e7;
  } vec_t;

  vec_t       vecs [6];
  logic [7:0] scan_an [8];
  logic [6:0] scan_seg [8];

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int  tu_cnt, tu_first;
    bit  found;

    vecs[0] = '{32'd2, 32'd0, 32'd12, 4'd9,  4'd3,  7'h3F, 7'h40, 7'h24, 7'h30, 7'h10};
    vecs[1] = '{32'd1, 32'd5, 32'd9,  4'd7,  4'd8,  7'h10, 7'h12, 7'h79, 7'h00, 7'h78};
    vecs[2] = '{32'd3, 32'd4, 32'd6,  4'd15, 4'd10, 7'h02, 7'h19, 7'h30, 7'h3F, 7'h3F};
    vecs[3] = '{32'h0001_0002, 32'd5, 32'd5, 4'd1, 4'd2, 7'h12, 7'h12, 7'h3F, 7'h24, 7'h79};
    vecs[4] = '{32'd9, 32'd8, 32'd7,  4'd4,  4'd5,  7'h78, 7'h00, 7'h10, 7'h12, 7'h19};
    vecs[5] = '{32'd0, 32'd0, 32'h8000_0000, 4'd0, 4'd6, 7'h3F, 7'h40, 7'h40, 7'h02, 7'h40};
    scan_an  = '{8'hFE, 8'hFD, 8'hFB, 8'hFF, 8'hFF, 8'hDF, 8'hFF, 8'h7F};
    scan_seg = '{7'h40, 7'h40, 7'h24, 7'h7F, 7'h7F, 7'h40, 7'h7F, 7'h40};

    // Held in reset
    m = 32'd2; s10 = 32'd0; s1 = 32'd0; score_l = 4'd0; score_r = 4'd0;
    reset = 1'b0;
    model_reset();
    repeat (3) @(negedge clk);
    chk("rst_an",  32'(an),      32'hFF);
    chk("rst_seg", 32'(seg),     32'h7F);
    chk("rst_dp",  32'(dp),      32'd1);
    chk("rst_tu",  32'(time_up), 32'd0);

    // Release: scan order and spacing
    reset = 1'b1;
    for (int j = 0; j < 32; j++) begin
      tick();
      chk("scan_an",  32'(an),  32'(scan_an[(mk - 1) / 4]));
      chk("scan_seg", 32'(seg), 32'(scan_seg[(mk - 1) / 4]));
    end

    // Table of static patterns
    for (int v = 0; v < 6; v++) begin
      m = vecs[v].vm; s10 = vecs[v].vs10; s1 = vecs[v].vs1;
      score_l = vecs[v].vsl; score_r = vecs[v].vsr;
      tick_n(33);
      check_frame($sformatf("vec%0d", v), vecs[v].e0, vecs[v].e1, vecs[v].e2,
                  vecs[v].e5, vecs[v].e7, 3'b111);
    end

    // Expiry: 0:01 -> 0:00 captured at the slot-2 boundary
    m = 32'd0; s10 = 32'd0; s1 = 32'd1; score_l = 4'd4; score_r = 4'd6;
    tick_n(33);
    goto_phase(5);
    s1 = 32'd0;
    found = 0;
    for (int g = 0; g < 40; g++) begin
      tick();
      if (time_up) begin found = 1; break; end
    end
    chk("tu_seen", 32'(found), 32'd1);
    chk("tu_edge", 32'(mk % 32), 32'd9);
    tick();
    chk("tu_one_cycle", 32'(time_up), 32'd0);
    check_frame("blink", 7'h40, 7'h40, 7'h40, 7'h02, 7'h19, 3'b100);
    tu_cnt = 0;
    for (int g = 0; g < 200; g++) begin
      tick();
      if (time_up) tu_cnt++;
    end
    chk("no_second_tu", 32'(tu_cnt), 32'd0);

    // Game clock reset to 2:00 stops the blink
    m = 32'd2;
    tick_n(5);
    check_frame("steady", 7'h40, 7'h40, 7'h24, 7'h02, 7'h19, 3'b111);

    // Reset during slot 5
    goto_phase(21);
    async_reset("midrst");
    tick_n(2);
    reset = 1'b1;
    tick();
    chk("midrst_first_an", 32'(an), 32'hFE);
    tu_cnt = 0;
    for (int g = 0; g < 40; g++) begin
      tick();
      if (time_up) tu_cnt++;
    end
    chk("midrst_no_tu", 32'(tu_cnt), 32'd0);

    // Leaving reset with inputs at 0:00
    async_reset("zrst");
    m = 32'd0; s10 = 32'd0; s1 = 32'd0;
    tick();
    reset = 1'b1;
    tu_cnt = 0; tu_first = -1;
    for (int g = 0; g < 100; g++) begin
      tick();
      if (time_up) begin
        tu_cnt++;
        if (tu_first < 0) tu_first = mk;
      end
    end
    chk("zrst_tu_count", 32'(tu_cnt), 32'd1);
    chk("zrst_tu_edge", 32'(tu_first), 32'd5);

    // Mid-slot stability
    m = 32'd2; s10 = 32'd0; s1 = 32'd4;
    tick_n(33);
    goto_phase(1);
    chk("stable_seg_a", 32'(seg), 32'h19);
    s1 = 32'd7;
    tick();
    chk("stable_seg_b", 32'(seg), 32'h19);
    tick();
    chk("stable_seg_c", 32'(seg), 32'h19);
    goto_phase(0);
    chk("stable_new_an",  32'(an),  32'hFE);
    chk("stable_new_seg", 32'(seg), 32'h78);

    // Randomized traffic against the model
    for (int c = 0; c < 3000; c++) begin
      if ($urandom_range(0, 9) == 0) begin
        m   = ($urandom_range(0, 15) == 0) ? $urandom() : 32'($urandom_range(0, 1) * $urandom_range(0, 3));
        s10 = 32'($urandom_range(0, 1) * $urandom_range(0, 7));
        s1  = 32'($urandom_range(0, 1) * $urandom_range(0, 12));
        score_l = 4'($urandom_range(0, 15));
        score_r = 4'($urandom_range(0, 15));
      end
      if ($urandom_range(0, 499) == 0) begin
        async_reset("rnd_rst");
        tick();
        reset = 1'b1;
      end
      tick();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
